// File: rtl/mealy_seq.sv
// mealy_seq -- serial-input Mealy detector for the pattern 1101, with
// overlapping matches allowed. It also keeps a shift-register history of the
// most recently sampled bits.
//
// Ports:
//   clk          : clock; all state updates on the rising edge
//   reset_n      : asynchronous, active-low reset
//   data_in      : serial data, one bit sampled per rising edge
//   seq_detected : combinational match flag, high while the 4th pattern bit
//                  is present on data_in
//   current_seq  : last WIDTH sampled bits, LSB newest, MSB oldest
//
// Parameters:
//   WIDTH        : history register width (>= 2)
module mealy_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             data_in,
  output logic             seq_detected,
  output logic [WIDTH-1:0] current_seq
);

  typedef enum logic [1:0] {
    S0   = 2'd0,
    S1   = 2'd1,
    S11  = 2'd2,
    S110 = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_detect;
  logic [WIDTH-1:0] r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S0;
    w_detect    = 1'b0;
    unique case (r_state)
      S0:   w_state_nxt = data_in ? S1  : S0;
      S1:   w_state_nxt = data_in ? S11 : S0;
      S11:  w_state_nxt = data_in ? S11 : S110;
      S110: begin
        // The closing 1 of a match doubles as the first 1 of the next one.
        w_state_nxt = data_in ? S1 : S0;
        w_detect    = data_in;
      end
      default: begin
        w_state_nxt = S0;
        w_detect    = 1'b0;
      end
    endcase
  end

  // Qualifying with reset_n keeps the flag low for the whole reset duration
  // even while data_in moves.
  assign seq_detected = w_detect & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[WIDTH-2:0], data_in};
    end
  end

  assign current_seq = r_hist;

endmodule

// File: tb/tb_mealy_seq.sv
module tb_mealy_seq;

  logic       clk;
  logic       reset_n;
  logic       data_in;
  logic       det4;
  logic       det8;
  logic [3:0] hist4;
  logic [7:0] hist8;

  int unsigned n_cmp;
  int unsigned n_bad;
  int unsigned n_det;
  bit          q[$];

  mealy_seq #(.WIDTH(4)) u_dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .seq_detected (det4),
    .current_seq  (hist4)
  );

  mealy_seq #(.WIDTH(8)) u_dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_in      (data_in),
    .seq_detected (det8),
    .current_seq  (hist8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a match is three samples ending in 1,1,0 followed by a 1 now on data_in.
  function automatic logic exp_det(input logic d);
    int unsigned n;
    n = q.size();
    if (!reset_n || n < 3) return 1'b0;
    return q[n-3] && q[n-2] && !q[n-1] && d;
  endfunction

  // Reference history: last w samples since reset, newest at bit 0, zeros before.
  function automatic logic [31:0] exp_hist(input int unsigned w);
    logic [31:0] r;
    int unsigned n;
    r = '0;
    n = q.size();
    for (int unsigned i = 0; i < w; i++)
      if (i < n) r[i] = q[n-1-i];
    return r;
  endfunction

  // Entered at posedge+1; drives mid-cycle, checks, samples, checks history; returns at posedge+1.
  task automatic cycle(input logic b);
    #3 data_in = b;
    #1;
    chk("det_w4", 32'(det4), 32'(exp_det(b)));
    chk("det_w8", 32'(det8), 32'(exp_det(b)));
    if (det4) n_det++;
    @(posedge clk);
    q.push_back(b);
    #1;
    chk("hist_w4", 32'(hist4), exp_hist(4));
    chk("hist_w8", 32'(hist8), exp_hist(8));
  endtask

  // Asserts reset between edges, holds it across one edge, releases between edges.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("rst_det_w4", 32'(det4), 32'd0);
    chk("rst_det_w8", 32'(det8), 32'd0);
    chk("rst_hist_w4", 32'(hist4), 32'd0);
    chk("rst_hist_w8", 32'(hist8), 32'd0);
    data_in = ~data_in;
    @(posedge clk);
    #1;
    chk("rst_hold_hist_w8", 32'(hist8), 32'd0);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [8:0] basic;
    n_cmp   = 0;
    n_bad   = 0;
    reset_n = 1'b0;
    data_in = 1'b0;

    // Reset held with data_in toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = ~data_in;
      #1;
      chk("in_rst_det", 32'(det4), 32'd0);
      chk("in_rst_hist", 32'(hist4), 32'd0);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic plus overlap: 0,1,1,0,1,1,0,1,0 -> two detections.
    basic = 9'b0_1011_0110; // bit i = stream index i
    n_det = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(basic[i]);
      if (i == 4 || i == 7) chk("basic_hist_1101", 32'(hist4), 32'hD);
    end
    chk("basic_ndet", n_det, 32'd2);

    // Near-miss 1,1,1,0,0,1: no detection.
    do_reset();
    n_det = 0;
    cycle(1'b1); cycle(1'b1); cycle(1'b1); cycle(1'b0); cycle(1'b0); cycle(1'b1);
    chk("nearmiss_ndet", n_det, 32'd0);

    // Mealy combinational toggle within one cycle while in S110.
    do_reset();
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    #1 data_in = 1'b0; #1 chk("comb_lo0", 32'(det4), 32'd0);
    data_in = 1'b1;    #1 chk("comb_hi",  32'(det4), 32'd1);
    data_in = 1'b0;    #1 chk("comb_lo1", 32'(det4), 32'd0);
    @(posedge clk);
    q.push_back(1'b0);
    #1;

    // Async reset mid-match while data_in = 1.
    do_reset();
    cycle(1'b1); cycle(1'b1); cycle(1'b0);
    #2 data_in = 1'b1;
    #1 chk("premrst_det", 32'(det4), 32'd1);
    reset_n = 1'b0;
    q.delete();
    #1;
    chk("mrst_det", 32'(det4), 32'd0);
    chk("mrst_hist", 32'(hist4), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    n_det = 0;
    cycle(1'b1);
    chk("post_mrst_ndet", n_det, 32'd0);

    // Wide history: 8 ones then 0.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1);
    cycle(1'b0);
    chk("hist_w8_fe", 32'(hist8), 32'hFE);
    chk("hist_w4_e", 32'(hist4), 32'hE);

    // Randomized stream, biased toward 1s, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      else cycle(logic'($urandom_range(0, 2) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
